// File: rtl/alu_serial_seq.sv
// alu_serial_seq
//   Bit-serial sequencer for an external 1-bit ALU slice. It accepts WIDTH-bit
//   operands over a valid/ready handshake and feeds the slice one bit per cycle,
//   LSB first. The slice carry is chained through a register. The WIDTH-bit
//   result and the C/Z/O/S flags are assembled here.
//
//   Optional feature: define ALU_SEQ_ABORT_EN to add the 'abort' input.
//   When abort is high in RUN or DONE, the block returns to IDLE on the next
//   edge. The previous result and flags are kept, and abort wins over out_ready.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready operand handshake (in_ready high only in IDLE)
//   op1, op2          operands; opsel, mode, cin_init also latched on accept
//   out_valid/out_ready result handshake (out_valid high only in DONE)
//   abort             (ALU_SEQ_ABORT_EN only) drop the current op
//   result            assembled result, held until the next op completes
//   c/z/o/s_flag      carry out of MSB, zero, signed overflow (0 in logic mode), sign
//   slice_*           drive/return of the external slice; outputs are 0 outside RUN
module alu_serial_seq #(
   parameter int WIDTH = 128
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op1,
   input  logic [WIDTH-1:0] op2,
   input  logic [2:0]       opsel,
   input  logic             mode,
   input  logic             cin_init,
   output logic             out_valid,
   input  logic             out_ready,
`ifdef ALU_SEQ_ABORT_EN
   input  logic             abort,
`endif
   output logic [WIDTH-1:0] result,
   output logic             c_flag,
   output logic             z_flag,
   output logic             o_flag,
   output logic             s_flag,
   output logic             slice_op1,
   output logic             slice_op2,
   output logic             slice_cin,
   output logic [2:0]       slice_opsel,
   output logic             slice_mode,
   input  logic             slice_result,
   input  logic             slice_cout
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] op1_sr, op2_sr, res_sr;
   logic [2:0]       opsel_q;
   logic             mode_q, carry_q;
   logic [CW-1:0]    cnt;

   logic             run, last_bit, abort_req;
   logic [WIDTH-1:0] res_next;

`ifdef ALU_SEQ_ABORT_EN
   assign abort_req = abort;
`else
   assign abort_req = 1'b0;
`endif

   assign run      = (state == RUN);
   assign last_bit = (cnt == CW'(WIDTH - 1));
   // Slice bit enters at the MSB and the register shifts right.
   // After WIDTH bits, bit 0 has reached position 0.
   assign res_next = {slice_result, res_sr[WIDTH-1:1]};

   assign in_ready    = (state == IDLE);
   assign slice_op1   = run & op1_sr[0];
   assign slice_op2   = run & op2_sr[0];
   assign slice_cin   = run & carry_q;
   assign slice_opsel = run ? opsel_q : 3'b000;
   assign slice_mode  = run & mode_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         op1_sr    <= '0;
         op2_sr    <= '0;
         res_sr    <= '0;
         opsel_q   <= '0;
         mode_q    <= 1'b0;
         carry_q   <= 1'b0;
         cnt       <= '0;
         out_valid <= 1'b0;
         result    <= '0;
         c_flag    <= 1'b0;
         z_flag    <= 1'b0;
         o_flag    <= 1'b0;
         s_flag    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  state   <= RUN;
                  op1_sr  <= op1;
                  op2_sr  <= op2;
                  opsel_q <= opsel;
                  mode_q  <= mode;
                  carry_q <= cin_init;
                  cnt     <= '0;
               end
            end
            RUN: begin
               if (abort_req) begin
                  state <= IDLE;
               end else begin
                  res_sr  <= res_next;
                  carry_q <= slice_cout;
                  op1_sr  <= op1_sr >> 1;
                  op2_sr  <= op2_sr >> 1;
                  if (last_bit) begin
                     // On this edge carry_q still holds the carry into the MSB.
                     // That is the value overflow needs.
                     state     <= DONE;
                     out_valid <= 1'b1;
                     result    <= res_next;
                     c_flag    <= slice_cout;
                     z_flag    <= (res_next == '0);
                     o_flag    <= mode_q ? 1'b0 : (carry_q ^ slice_cout);
                     s_flag    <= slice_result;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            DONE: begin
               if (abort_req || out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_serial_seq.sv
// Self-checking bench for alu_serial_seq (WIDTH=8).
// It contains a behavioural slice: mode 0 is a full adder, mode 1 is a&b with cout=0.
// Expected results come from whole-word arithmetic on the operands.
module tb_alu_serial_seq;
   localparam int W = 8;

   logic         clk = 1'b0, rst_n = 1'b0;
   logic         in_valid = 1'b0, out_ready = 1'b0;
   logic [W-1:0] op1 = '0, op2 = '0;
   logic [2:0]   opsel = '0;
   logic         mode = 1'b0, cin_init = 1'b0;
   logic         in_ready, out_valid;
   logic [W-1:0] result;
   logic         c_flag, z_flag, o_flag, s_flag;
   logic         slice_op1, slice_op2, slice_cin, slice_mode, slice_result, slice_cout;
   logic [2:0]   slice_opsel;
`ifdef ALU_SEQ_ABORT_EN
   logic         abort = 1'b0;
`endif

   int errs = 0, checks = 0;
   logic [W-1:0] last_res = '0;
   logic [3:0]   last_flags = '0;

   always #5 clk = ~clk;

   assign slice_result = slice_mode ? (slice_op1 & slice_op2) : (slice_op1 ^ slice_op2 ^ slice_cin);
   assign slice_cout   = slice_mode ? 1'b0 :
                         ((slice_op1 & slice_op2) | (slice_cin & (slice_op1 ^ slice_op2)));

   alu_serial_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op1(op1), .op2(op2), .opsel(opsel), .mode(mode), .cin_init(cin_init),
      .out_valid(out_valid), .out_ready(out_ready),
`ifdef ALU_SEQ_ABORT_EN
      .abort(abort),
`endif
      .result(result), .c_flag(c_flag), .z_flag(z_flag), .o_flag(o_flag), .s_flag(s_flag),
      .slice_op1(slice_op1), .slice_op2(slice_op2), .slice_cin(slice_cin),
      .slice_opsel(slice_opsel), .slice_mode(slice_mode),
      .slice_result(slice_result), .slice_cout(slice_cout)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference result: {c, z, o, s, result}.
   function automatic logic [W+3:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic m, input logic ci);
      logic [W:0]   sum;
      logic [W-1:0] r;
      logic         c, o;
      if (m) begin
         r = a & b; c = 1'b0; o = 1'b0;
      end else begin
         sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
         r = sum[W-1:0];
         c = sum[W];
         o = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      return {c, (r == '0), o, r[W-1], r};
   endfunction

   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic m, input logic ci);
      @(negedge clk);
      chk("in_ready_idle", in_ready, 1'b1);
      op1 = a; op2 = b; mode = m; cin_init = ci; opsel = 3'($urandom);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Waits for out_valid and checks latency and outputs.
   // It then holds DONE for 'hold' cycles with a stray in_valid pulse, and releases.
   task automatic finish_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic m, input logic ci, input int hold);
      logic [W+3:0] e;
      int n;
      e = ref_op(a, b, m, ci);
      n = 0;
      for (int i = 1; i <= W + 4; i++) begin
         @(posedge clk); #1;
         if (out_valid) begin n = i; break; end
      end
      chk("latency", 64'(n), 64'(W));
      chk("result", result, e[W-1:0]);
      chk("flags_czos", {c_flag, z_flag, o_flag, s_flag}, e[W+3:W]);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         in_valid = (i == 4);
         op1 = 8'($urandom); op2 = 8'($urandom);
         @(posedge clk); #1;
         chk("hold_result", result, e[W-1:0]);
         chk("hold_valid", out_valid, 1'b1);
         chk("hold_in_ready", in_ready, 1'b0);
      end
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("release_valid", out_valid, 1'b0);
      chk("release_in_ready", in_ready, 1'b1);
      chk("idle_result", result, e[W-1:0]);
      last_res = e[W-1:0];
      last_flags = e[W+3:W];
   endtask

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic m, input logic ci, input int hold);
      start_op(a, b, m, ci);
      finish_op(a, b, m, ci, hold);
   endtask

   task automatic no_valid_window(input string tag);
      logic seen = 1'b0;
      for (int i = 0; i < W + 3; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      chk(tag, seen, 1'b0);
   endtask

   initial begin
      // Reset state.
      #12;
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_out_valid", out_valid, 1'b0);
      @(negedge clk); rst_n = 1'b1;

      // Reset mid-run: outputs clear at once and no result appears.
      start_op(8'hAA, 8'h55, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_in_ready", in_ready, 1'b1);
      chk("midrst_out_valid", out_valid, 1'b0);
      chk("midrst_result", result, 8'h00);
      chk("midrst_flags", {c_flag, z_flag, o_flag, s_flag}, 4'h0);
      @(negedge clk); rst_n = 1'b1;
      no_valid_window("midrst_no_valid");
      run_op(8'h01, 8'h01, 1'b0, 1'b0, 0);

      // Directed corner cases.
      run_op(8'hFF, 8'h01, 1'b0, 1'b0, 0);
      run_op(8'h7F, 8'h01, 1'b0, 1'b0, 0);
      run_op(8'hF0, 8'h3C, 1'b1, 1'b0, 0);
      run_op(8'h80, 8'h80, 1'b0, 1'b1, 10);

`ifdef ALU_SEQ_ABORT_EN
      // Abort at bit 3: back to IDLE with the previous result kept.
      start_op(8'hAA, 8'h55, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk); abort = 1'b1;
      @(posedge clk); #1; abort = 1'b0;
      chk("abort_in_ready", in_ready, 1'b1);
      chk("abort_out_valid", out_valid, 1'b0);
      chk("abort_result", result, last_res);
      chk("abort_flags", {c_flag, z_flag, o_flag, s_flag}, last_flags);
      no_valid_window("abort_no_valid");
      run_op(8'h01, 8'h01, 1'b0, 1'b0, 0);
`endif

      // Randomized operations.
      for (int t = 0; t < 40; t++)
         run_op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule
